// File: rtl/ltmr_vote_monitor.sv
// ltmr_vote_monitor: majority voter and health monitor for an LTMR register triplet.
//
// This block replaces a bare majority voter. It registers the bitwise majority of the three
// replicas and sorts each replica's disagreements into transient errors or permanent faults.
// It also keeps a saturating mismatch count per replica.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   port_en           sample strobe; replicas evaluated only when high
//   port_rep_0..2     replica register outputs
//   port_clr          level clear request for counters, sticky flags and replica FSMs
//   port_out          registered majority word (holds when not sampling)
//   port_valid        high the cycle after a sampled cycle
//   port_mis          per-replica mismatch of the last sample
//   port_multi_err    two or more replicas mismatched in the same sample
//   port_transient    sticky: replica recovered after mismatching
//   port_perm_fault   sticky: replica hit PERSIST_TH consecutive mismatches
//   port_err_cnt_0..2 saturating per-replica mismatch counts
//   port_clr_ack      one-cycle pulse acknowledging a clear
module ltmr_vote_monitor #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERSIST_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_en,
  input  logic [WIDTH-1:0] port_rep_0,
  input  logic [WIDTH-1:0] port_rep_1,
  input  logic [WIDTH-1:0] port_rep_2,
  input  logic             port_clr,
  output logic [WIDTH-1:0] port_out,
  output logic             port_valid,
  output logic [2:0]       port_mis,
  output logic             port_multi_err,
  output logic [2:0]       port_transient,
  output logic [2:0]       port_perm_fault,
  output logic [CNT_W-1:0] port_err_cnt_0,
  output logic [CNT_W-1:0] port_err_cnt_1,
  output logic [CNT_W-1:0] port_err_cnt_2,
  output logic             port_clr_ack
);

  localparam int unsigned ConsecW = 8;
  localparam logic [ConsecW-1:0] PersistTh = ConsecW'(PERSIST_TH);

  typedef enum logic [1:0] {StOk, StSuspect, StFailed} rep_state_e;

  logic [WIDTH-1:0] rep [3];
  logic [WIDTH-1:0] vote;
  logic [2:0]       mis;
  logic             multi;
  logic             clr_edge;
  logic             stats_upd;

  logic [WIDTH-1:0]   out_d, out_q;
  logic               valid_d, valid_q;
  logic [2:0]         mis_d, mis_q;
  logic               multi_d, multi_q;
  logic [2:0]         transient_d, transient_q;
  logic [2:0]         perm_d, perm_q;
  logic [CNT_W-1:0]   cnt_d [3];
  logic [CNT_W-1:0]   cnt_q [3];
  logic [ConsecW-1:0] consec_d [3];
  logic [ConsecW-1:0] consec_q [3];
  rep_state_e         state_d [3];
  rep_state_e         state_q [3];
  logic               clr_prev_d, clr_prev_q;
  logic               clr_ack_d, clr_ack_q;

  always_comb begin
    rep[0] = port_rep_0;
    rep[1] = port_rep_1;
    rep[2] = port_rep_2;
    vote   = (port_rep_0 & port_rep_1) | (port_rep_1 & port_rep_2) | (port_rep_0 & port_rep_2);
    for (int i = 0; i < 3; i++) begin
      mis[i] = |(rep[i] ^ vote);
    end
    multi = (mis[0] & mis[1]) | (mis[1] & mis[2]) | (mis[0] & mis[2]);
  end

  // clr_prev_q resets to 0 so a request held through reset still yields one clear and ack.
  assign clr_edge  = port_clr & ~clr_prev_q;
  // While the request stays high after its edge, statistics stay frozen at zero.
  assign stats_upd = port_en & ~port_clr;

  always_comb begin
    out_d       = port_en ? vote : out_q;
    valid_d     = port_en;
    mis_d       = port_en ? mis : 3'b000;
    multi_d     = port_en & multi;
    clr_prev_d  = port_clr;
    clr_ack_d   = clr_edge;
    transient_d = transient_q;
    perm_d      = perm_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]    = cnt_q[i];
      consec_d[i] = consec_q[i];
      state_d[i]  = state_q[i];
    end

    if (clr_edge) begin
      transient_d = '0;
      perm_d      = '0;
      for (int i = 0; i < 3; i++) begin
        cnt_d[i]    = '0;
        consec_d[i] = '0;
        state_d[i]  = StOk;
      end
    end else if (stats_upd) begin
      for (int i = 0; i < 3; i++) begin
        if (mis[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        unique case (state_q[i])
          StOk: begin
            if (mis[i]) begin
              state_d[i]  = StSuspect;
              consec_d[i] = ConsecW'(1);
            end
          end
          StSuspect: begin
            if (mis[i]) begin
              consec_d[i] = consec_q[i] + ConsecW'(1);
              if ((consec_q[i] + ConsecW'(1)) == PersistTh) begin
                state_d[i] = StFailed;
                perm_d[i]  = 1'b1;
              end
            end else begin
              state_d[i]     = StOk;
              consec_d[i]    = '0;
              transient_d[i] = 1'b1;
            end
          end
          // Absorbing until cleared; mismatches are still counted above.
          StFailed: ;
          default: state_d[i] = StOk;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      valid_q     <= 1'b0;
      mis_q       <= '0;
      multi_q     <= 1'b0;
      transient_q <= '0;
      perm_q      <= '0;
      clr_prev_q  <= 1'b0;
      clr_ack_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]    <= '0;
        consec_q[i] <= '0;
        state_q[i]  <= StOk;
      end
    end else begin
      out_q       <= out_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      multi_q     <= multi_d;
      transient_q <= transient_d;
      perm_q      <= perm_d;
      clr_prev_q  <= clr_prev_d;
      clr_ack_q   <= clr_ack_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]    <= cnt_d[i];
        consec_q[i] <= consec_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  assign port_out        = out_q;
  assign port_valid      = valid_q;
  assign port_mis        = mis_q;
  assign port_multi_err  = multi_q;
  assign port_transient  = transient_q;
  assign port_perm_fault = perm_q;
  assign port_err_cnt_0  = cnt_q[0];
  assign port_err_cnt_1  = cnt_q[1];
  assign port_err_cnt_2  = cnt_q[2];
  assign port_clr_ack    = clr_ack_q;

endmodule
